// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Contents: instruction width, default queue depth and address width,
// and the fetch FSM state encoding.
package fetch_pkg;

    localparam int unsigned INSTR_W        = 32;
    localparam int unsigned DEPTH_DEFAULT  = 2;
    localparam int unsigned ADDR_W_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO holding fetched {address, instruction} entries.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i, data_i  write an entry at the tail
//   pop_i           retire the head entry (ignored when empty)
//   clear_i         drop all entries; wins over push/pop
//   full_o, empty_o occupancy flags
//   count_o         number of valid entries
//   head_o          head entry, held in a register
module fetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 96
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [W-1:0]               head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    // Pointer and count next state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        push_ok = push_i & ~clear_i;
        pop_ok  = pop_i & ~clear_i & ~empty_o;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + PTR_W'(1);
            if (pop_ok)  rd_d = rd_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) mem_q[wr_q] <= data_i;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Issue is gated upstream, so a push into a full queue means a logic bug.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !clear_i && full_o));

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one memory request at a time for pc_addr,
// queues returned words with their address, and presents the queue head to
// decode. A flush discards queued entries and any in-flight response.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   pc_addr / pc_advance        PC input and its "consumed" pulse
//   flush                       redirect; drop queued and in-flight fetches
//   imem_req/addr/gnt           request handshake toward instruction memory
//   imem_rsp_valid/data         response from instruction memory
//   if_valid/ready/pc/instr     head of the instruction queue toward decode
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   pc_addr,
    output logic                pc_advance,
    input  logic                flush,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rsp_valid,
    input  logic [INSTR_W-1:0]  imem_rsp_data,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [ADDR_W-1:0]   if_pc,
    output logic [INSTR_W-1:0]  if_instr
);

    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               q_push;
    logic               q_pop;
    logic               q_full;
    logic               q_empty;
    logic [CNT_W-1:0]   q_count;
    logic [CNT_W-1:0]   post_cnt;
    logic [ENTRY_W-1:0] q_head;

    fetch_queue #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (q_push),
        .data_i  ({addr_q, imem_rsp_data}),
        .pop_i   (q_pop),
        .clear_i (flush),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count),
        .head_o  (q_head)
    );

    // Next state, queue push/pop and request address capture.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        q_push   = 1'b0;
        q_pop    = ~q_empty & if_ready & ~flush;
        // Occupancy after this cycle's push and possible pop.
        post_cnt = q_count + CNT_W'(1) - CNT_W'(q_pop);
        case (state_q)
            ST_IDLE: begin
                if (!q_full && !flush) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (flush)         state_d = imem_gnt ? ST_DROP : ST_IDLE;
                else if (imem_gnt) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = imem_rsp_valid ? ST_IDLE : ST_DROP;
                end else if (imem_rsp_valid) begin
                    q_push  = 1'b1;
                    state_d = (post_cnt < CNT_W'(DEPTH)) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DROP: begin
                if (imem_rsp_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Capture the PC whenever a new request is about to be raised.
        if (state_d == ST_REQ && state_q != ST_REQ) addr_d = pc_addr;
    end

    // State and request address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // The PC stage must see the grant in the same cycle, so this pulse is decoded live.
    assign pc_advance = (state_q == ST_REQ) & imem_gnt & ~flush;
    assign imem_req   = (state_q == ST_REQ);
    assign imem_addr  = addr_q;
    assign if_valid   = ~q_empty;
    assign if_pc      = q_head[ENTRY_W-1 -: ADDR_W];
    assign if_instr   = q_head[INSTR_W-1:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch: a memory model answers
// grants with 1..3 cycle latency, a PC model advances on pc_advance and jumps
// on flush, and a monitor checks every word handed to decode in order.
module tb_instruction_fetch;

    localparam int unsigned DEPTH  = 2;
    localparam int unsigned ADDR_W = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [ADDR_W-1:0] pc_addr = '0;
    logic              pc_advance;
    logic              flush = 1'b0;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt = 1'b0;
    logic              imem_rsp_valid = 1'b0;
    logic [31:0]       imem_rsp_data = '0;
    logic              if_valid;
    logic              if_ready = 1'b0;
    logic [ADDR_W-1:0] if_pc;
    logic [31:0]       if_instr;

    always #5 clk = ~clk;

    instruction_fetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_addr        (pc_addr),
        .pc_advance     (pc_advance),
        .flush          (flush),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [63:0] exp_q [$];   // accepted fetch addresses not yet delivered
    logic [63:0] pc = '0;     // PC stage model
    int          occ = 0;     // entries the queue should hold
    bit          inflight = 1'b0;
    int          rsp_cnt = 0;
    logic [63:0] rsp_addr = '0;
    bit          late_rsp = 1'b0;
    bit          rst_done = 1'b0;
    int          cyc = 0;

    // Memory contents: address 0 holds 0x00000013.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_imem_req",   64'(imem_req),   64'd0);
        check("rst_pc_advance", 64'(pc_advance), 64'd0);
        check("rst_if_valid",   64'(if_valid),   64'd0);
        check("rst_imem_addr",  imem_addr,       64'd0);
        check("rst_if_pc",      if_pc,           64'd0);
        check("rst_if_instr",   64'(if_instr),   64'd0);
    endtask

    // One clock cycle: drive at posedge+1, check and update models at negedge.
    task automatic step(input bit drain);
        bit pop;
        @(posedge clk);
        #1;
        if (!rst_n) rst_n = 1'b1;
        flush          = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (late_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
            late_rsp       = 1'b0;
        end else if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(rsp_addr);
            end
        end
        pc_addr = pc;
        if (drain) begin
            imem_gnt = 1'b0;
            if_ready = 1'b1;
        end else begin
            imem_gnt = imem_req && ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            if_ready = (cyc < 150) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
        end

        @(negedge clk);
        check("pc_advance", 64'(pc_advance), 64'(imem_req && imem_gnt && !flush));
        if (imem_req) begin
            check("imem_addr", imem_addr, pc);
            check("req_with_room", 64'(occ < int'(DEPTH)), 64'd1);
        end
        check("if_valid", 64'(if_valid), 64'(occ != 0));
        if (imem_req && imem_gnt) begin
            check("one_outstanding", 64'(rsp_cnt), 64'd0);
            rsp_cnt  = $urandom_range(1, 3);
            rsp_addr = imem_addr;
        end

        pop = (occ > 0) && if_ready && !flush;
        if (flush) begin
            exp_q.delete();
            occ      = 0;
            inflight = 1'b0;
            pc       = {$urandom, $urandom} & ~64'h3;
        end else begin
            if (imem_rsp_valid && inflight) begin
                occ++;
                inflight = 1'b0;
            end
            if (pop) occ--;
            if (pc_advance) begin
                exp_q.push_back(pc);
                inflight = 1'b1;
                pc       = pc + 64'd4;
            end
        end

        // Asynchronous reset while a response is still outstanding.
        if (!drain && cyc >= 400 && !rst_done && rsp_cnt >= 1 && !(imem_req && imem_gnt)) begin
            rst_n    = 1'b0;
            imem_gnt = 1'b0;
            #1;
            check_reset_outputs();
            exp_q.delete();
            occ      = 0;
            inflight = 1'b0;
            rsp_cnt  = 0;
            late_rsp = 1'b1;
            rst_done = 1'b1;
        end
    endtask

    // Monitor: every word accepted by decode must be the oldest live fetch.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && if_valid && if_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got pc 0x%0h, required no entry (cycle %0d)", if_pc, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("if_pc", if_pc, e);
                    check("if_instr", 64'(if_instr), 64'(mem_word(e)));
                end
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #2 check_reset_outputs();
        repeat (2) @(posedge clk);
        for (int i = 0; i < 2000; i++) begin
            cyc = i;
            step(1'b0);
        end
        for (int i = 0; i < 30; i++) begin
            cyc = 2000 + i;
            step(1'b1);
        end
        check("drain_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("drain_if_valid", 64'(if_valid), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: DEPTH, 2, instruction queue entries (power of two, >=2).
REQ-002 Parameter: ADDR_W, 64, instruction address width.
REQ-003 Port: clk  in  1  single clock; all state updates on posedge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: pc_addr  in  ADDR_W  current instruction address from the program counter stage.
REQ-006 Port: pc_advance  out  1  one-cycle pulse: pc_addr consumed, PC may advance; PC holds while low.
REQ-007 Port: flush  in  1  redirect/branch taken; discard queued and in-flight fetches.
REQ-008 Port: imem_req  out  1  instruction memory request valid.
REQ-009 Port: imem_addr  out  ADDR_W  request address, stable while imem_req=1 and imem_gnt=0.
REQ-010 Port: imem_gnt  in  1  memory accepts request this cycle.
REQ-011 Port: imem_rsp_valid  in  1  response data valid, one cycle per granted request, >=1 cycle after grant.
REQ-012 Port: imem_rsp_data  in  32  fetched instruction word.
REQ-013 Port: if_valid  out  1  queue head valid toward decode.
REQ-014 Port: if_ready  in  1  decode accepts head this cycle.
REQ-015 Port: if_pc  out  ADDR_W  address of head instruction.
REQ-016 Port: if_instr  out  32  head instruction word.

Function
REQ-017 FSM states IDLE, REQ, WAIT, DROP; at most one request outstanding.
REQ-018 IDLE->REQ when queue count < DEPTH and flush=0; pc_addr latched into imem_addr on that edge.
REQ-019 REQ: imem_req=1; on imem_gnt=1 and flush=0 -> WAIT, pc_advance=1 that cycle.
REQ-020 REQ with flush=1 and imem_gnt=0 -> IDLE, request withdrawn, pc_advance=0.
REQ-021 REQ with flush=1 and imem_gnt=1 -> DROP, pc_advance=0.
REQ-022 WAIT: on imem_rsp_valid push {latched addr, imem_rsp_data} into queue; next state REQ if post-push/pop count < DEPTH, else IDLE.
REQ-023 WAIT with flush=1 (with or without imem_rsp_valid same cycle) -> response discarded; DROP if rsp not yet seen, else IDLE.
REQ-024 DROP: imem_req=0; on imem_rsp_valid discard data -> IDLE.
REQ-025 flush clears queue (count=0, if_valid=0 next cycle) regardless of state; pop on same cycle ignored.
REQ-026 Queue: head pops when if_valid & if_ready; push and pop in same cycle keep count unchanged.
REQ-027 Push into full queue cannot occur (issue gated by REQ-018); overflow is an assertion failure.
REQ-028 if_valid = (count != 0); if_pc/if_instr driven from head register, stable while if_valid & !if_ready.
REQ-029 Latency: response at cycle t -> if_valid=1 at t+1 when queue was empty.
REQ-030 Queue pointers wrap modulo DEPTH.

Reset
REQ-031 rst_n=0 asynchronously forces state IDLE, count=0, pointers=0, imem_req=0, pc_advance=0, if_valid=0, imem_addr=0, if_pc=0, if_instr=0.
REQ-032 Reset mid-transaction abandons any outstanding request; a response arriving after rst_n release while IDLE is ignored.

Structure
REQ-033 Package fetch_pkg holds FSM state enum, DEPTH default, instruction width constant (32).
REQ-034 Queue implemented as sub-module fetch_queue (push, pop, clear, full, empty, head).

Verification
REQ-035 Reset, pc_addr=0x0, gnt immediate, rsp 1 cycle later data 0x00000013 -> if_valid=1, if_pc=0x0, if_instr=0x00000013; pc_advance pulsed once.
REQ-036 if_ready=0, three fetches at 0x0,0x4,0x8 -> queue holds 2 entries, imem_req stays 0 until one pop, third fetch then issues at 0x8.
REQ-037 flush while WAIT for 0x10, rsp 0xDEADBEEF arrives 3 cycles later -> discarded, if_valid=0, next fetch from new pc_addr 0x100.
REQ-038 flush same cycle as imem_gnt for 0x20 -> pc_advance=0, DROP, response dropped, no queue entry.
REQ-039 Back-to-back pop and push with count=1 -> count remains 1, order 0x30 then 0x34 preserved.
REQ-040 rst_n low mid-WAIT -> all outputs 0 immediately; late response ignored, first post-reset fetch at pc_addr.
